// File: rtl/io_cycle_sequencer.sv
// io_cycle_sequencer: bus-side engine for IN r,(C) / OUT (C),r.
// Consumes the per-step decoder strobes, runs the IORQ/RD/WR handshake,
// stretches TW on notWAIT, and latches IN data for the write-back step.
module io_cycle_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  notReset,
  input  logic                  PC_I0,
  input  logic                  PC_I1,
  input  logic                  PC_I2,
  input  logic                  PC_I3,
  input  logic                  PC_O0,
  input  logic                  PC_O1,
  input  logic                  PC_O2,
  input  logic                  PC_O3,
  input  logic [ADDR_WIDTH-1:0] AddrBC,
  input  logic [7:0]            DataOut,
  input  logic [7:0]            BusDataIn,
  input  logic                  notWAIT,
  output logic [ADDR_WIDTH-1:0] BusAddr,
  output logic [7:0]            BusDataOut,
  output logic                  BusDataOE,
  output logic                  notIORQ,
  output logic                  notRD,
  output logic                  notWR,
  output logic [7:0]            InData,
  output logic                  InDataValid,
  output logic                  Stall,
  output logic                  ProtoErr,
  output logic                  Timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
  } state_t;

  state_t                r_state;
  logic                  r_dir;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_dout;
  logic                  r_oe;
  logic                  r_iorq_n;
  logic                  r_rd_n;
  logic                  r_wr_n;
  logic [7:0]            r_in_data;
  logic                  r_in_valid;
  logic                  r_proto_err;
  logic                  r_timeout;
  logic                  r_notwait_q;
  logic [7:0]            r_waitcnt;

  logic [7:0] w_strb;
  logic       w_any;
  logic       w_one;
  logic       w_sdir;
  logic [1:0] w_sidx;
  logic       w_x0;
  logic       w_same1;
  logic       w_same2;
  logic       w_same3;
  logic       w_stall;
  logic       w_start;
  logic       w_open;
  logic       w_capture;
  logic       w_close;
  logic       w_illegal;
  logic       w_tmo;
  logic       w_wait_clr;
  state_t     w_nxt;

  assign w_strb  = {PC_O3, PC_O2, PC_O1, PC_O0, PC_I3, PC_I2, PC_I1, PC_I0};
  assign w_any   = |w_strb;
  assign w_one   = w_any && ((w_strb & (w_strb - 8'd1)) == 8'd0);
  assign w_sdir  = |w_strb[7:4];
  assign w_x0    = w_one && (w_sidx == 2'd0);
  assign w_same1 = w_one && (w_sidx == 2'd1) && (w_sdir == r_dir);
  assign w_same2 = w_one && (w_sidx == 2'd2) && (w_sdir == r_dir);
  assign w_same3 = w_one && (w_sidx == 2'd3) && (w_sdir == r_dir);
  assign w_stall = (r_state == S_TW) && !r_notwait_q;

  // Step index of the active strobe, meaningful only when exactly one is high
  always_comb begin
    w_sidx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_strb[i] || w_strb[i+4]) w_sidx = 2'(i);
    end
  end

  // Classify this cycle's strobe against the current state into bus events
  always_comb begin
    w_start    = 1'b0;
    w_open     = 1'b0;
    w_capture  = 1'b0;
    w_close    = 1'b0;
    w_illegal  = 1'b0;
    w_tmo      = 1'b0;
    w_wait_clr = 1'b0;
    w_nxt      = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_x0) begin
          w_start = 1'b1;
          w_nxt   = S_T1;
        end else if (w_any) begin
          w_illegal = 1'b1;
        end
      end
      S_T1: begin
        if (w_same1) begin
          w_open = 1'b1;
          w_nxt  = S_T2;
        end else if (w_any) begin
          w_illegal = 1'b1;
        end
      end
      S_T2: begin
        if (w_same2) begin
          w_wait_clr = 1'b1;
          w_nxt      = S_TW;
        end else if (w_any) begin
          w_illegal = 1'b1;
        end
      end
      S_TW: begin
        // Timeout outranks whatever strobe arrives on the expiring cycle
        if (w_stall && (r_waitcnt == 8'(WAIT_TIMEOUT))) begin
          w_tmo = 1'b1;
        end else if (w_same3 && r_notwait_q) begin
          w_capture = !r_dir;
          w_nxt     = S_T3;
        end else if (w_any && !w_same2) begin
          w_illegal = 1'b1;
        end
      end
      S_T3: begin
        w_close = 1'b1;
        if (w_x0) begin
          w_start = 1'b1;
          w_nxt   = S_T1;
        end else if (w_any) begin
          w_illegal = 1'b1;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_illegal || w_tmo) w_nxt = S_IDLE;
  end

  // Wait request is sampled once so Stall only ever follows registered state
  always_ff @(posedge CLK or negedge notReset) begin
    if (!notReset) r_notwait_q <= 1'b1;
    else           r_notwait_q <= notWAIT;
  end

  // Cycle FSM with registered bus strobes, latches, wait counter and flags
  always_ff @(posedge CLK or negedge notReset) begin
    if (!notReset) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_oe        <= 1'b0;
      r_iorq_n    <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_in_data   <= '0;
      r_in_valid  <= 1'b0;
      r_proto_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_waitcnt   <= '0;
    end else begin
      r_state    <= w_nxt;
      r_in_valid <= 1'b0;
      if (w_start) begin
        r_dir  <= w_sdir;
        r_addr <= AddrBC;
        if (w_sdir) r_dout <= DataOut;
      end
      if (w_open) begin
        r_iorq_n <= 1'b0;
        r_rd_n   <= r_dir;
        r_wr_n   <= !r_dir;
        r_oe     <= r_dir;
      end
      if (w_close || w_illegal || w_tmo) begin
        r_iorq_n <= 1'b1;
        r_rd_n   <= 1'b1;
        r_wr_n   <= 1'b1;
        r_oe     <= 1'b0;
      end
      if (w_capture) begin
        r_in_data  <= BusDataIn;
        r_in_valid <= 1'b1;
      end
      if (w_illegal) r_proto_err <= 1'b1;
      if (w_tmo)     r_timeout   <= 1'b1;
      if (w_wait_clr)                   r_waitcnt <= '0;
      else if (w_stall && !w_tmo)       r_waitcnt <= r_waitcnt + 8'd1;
    end
  end

  assign BusAddr     = r_addr;
  assign BusDataOut  = r_dout;
  assign BusDataOE   = r_oe;
  assign notIORQ     = r_iorq_n;
  assign notRD       = r_rd_n;
  assign notWR       = r_wr_n;
  assign InData      = r_in_data;
  assign InDataValid = r_in_valid;
  assign Stall       = w_stall;
  assign ProtoErr    = r_proto_err;
  assign Timeout     = r_timeout;

endmodule

// File: tb/tb_io_cycle_sequencer.sv
// Directed bench for io_cycle_sequencer (WAIT_TIMEOUT=4).
module tb_io_cycle_sequencer;

  logic        CLK;
  logic        notReset;
  logic [3:0]  pci;
  logic [3:0]  pco;
  logic [15:0] AddrBC;
  logic [7:0]  DataOut;
  logic [7:0]  BusDataIn;
  logic        notWAIT;
  logic [15:0] BusAddr;
  logic [7:0]  BusDataOut;
  logic        BusDataOE;
  logic        notIORQ;
  logic        notRD;
  logic        notWR;
  logic [7:0]  InData;
  logic        InDataValid;
  logic        Stall;
  logic        ProtoErr;
  logic        Timeout;

  int unsigned n_vec;
  int unsigned n_err;

  io_cycle_sequencer #(
    .ADDR_WIDTH  (16),
    .WAIT_TIMEOUT(4)
  ) dut (
    .CLK        (CLK),
    .notReset   (notReset),
    .PC_I0      (pci[0]),
    .PC_I1      (pci[1]),
    .PC_I2      (pci[2]),
    .PC_I3      (pci[3]),
    .PC_O0      (pco[0]),
    .PC_O1      (pco[1]),
    .PC_O2      (pco[2]),
    .PC_O3      (pco[3]),
    .AddrBC     (AddrBC),
    .DataOut    (DataOut),
    .BusDataIn  (BusDataIn),
    .notWAIT    (notWAIT),
    .BusAddr    (BusAddr),
    .BusDataOut (BusDataOut),
    .BusDataOE  (BusDataOE),
    .notIORQ    (notIORQ),
    .notRD      (notRD),
    .notWR      (notWR),
    .InData     (InData),
    .InDataValid(InDataValid),
    .Stall      (Stall),
    .ProtoErr   (ProtoErr),
    .Timeout    (Timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance past one rising edge and let registered outputs settle
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic iorq, input logic rd, input logic wr);
    check({tag, ".notIORQ"}, 32'(notIORQ), 32'(iorq));
    check({tag, ".notRD"},   32'(notRD),   32'(rd));
    check({tag, ".notWR"},   32'(notWR),   32'(wr));
  endtask

  task automatic check_reset_vals(input string tag);
    check_strobes(tag, 1'b1, 1'b1, 1'b1);
    check({tag, ".oe"},     32'(BusDataOE),   32'h0);
    check({tag, ".addr"},   32'(BusAddr),     32'h0);
    check({tag, ".dout"},   32'(BusDataOut),  32'h0);
    check({tag, ".indata"}, 32'(InData),      32'h0);
    check({tag, ".valid"},  32'(InDataValid), 32'h0);
    check({tag, ".stall"},  32'(Stall),       32'h0);
    check({tag, ".perr"},   32'(ProtoErr),    32'h0);
    check({tag, ".tmo"},    32'(Timeout),     32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    notReset  = 1'b1;
    pci       = '0;
    pco       = '0;
    AddrBC    = '0;
    DataOut   = '0;
    BusDataIn = '0;
    notWAIT   = 1'b1;
    #1 notReset = 1'b0;
    #1 check_reset_vals("rst");
    repeat (2) @(posedge CLK);
    #1 notReset = 1'b1;

    // IN, no wait
    AddrBC = 16'h12FE; pci = 4'b0001; tick();
    check("in.e0.addr", 32'(BusAddr), 32'h12FE);
    check_strobes("in.e0", 1'b1, 1'b1, 1'b1);
    AddrBC = 16'hFFFF; pci = 4'b0010; tick();
    check_strobes("in.e1", 1'b0, 1'b0, 1'b1);
    check("in.e1.oe", 32'(BusDataOE), 32'h0);
    pci = 4'b0100; tick();
    check_strobes("in.e2", 1'b0, 1'b0, 1'b1);
    check("in.e2.stall", 32'(Stall), 32'h0);
    pci = 4'b1000; BusDataIn = 8'h5A; tick();
    check_strobes("in.e3", 1'b0, 1'b0, 1'b1);
    check("in.e3.indata", 32'(InData), 32'h5A);
    check("in.e3.valid", 32'(InDataValid), 32'h1);
    check("in.e3.oe", 32'(BusDataOE), 32'h0);
    pci = 4'b0000; BusDataIn = 8'h00; tick();
    check_strobes("in.e4", 1'b1, 1'b1, 1'b1);
    check("in.e4.valid", 32'(InDataValid), 32'h0);
    check("in.e4.indata", 32'(InData), 32'h5A);
    check("in.e4.addr", 32'(BusAddr), 32'h12FE);

    // OUT with three wait cycles
    AddrBC = 16'h00A5; DataOut = 8'hC3; pco = 4'b0001; tick();
    check("out.e0.dout", 32'(BusDataOut), 32'hC3);
    check("out.e0.addr", 32'(BusAddr), 32'h00A5);
    DataOut = 8'h00; pco = 4'b0010; tick();
    check_strobes("out.e1", 1'b0, 1'b1, 1'b0);
    check("out.e1.oe", 32'(BusDataOE), 32'h1);
    pco = 4'b0100; notWAIT = 1'b0; tick();
    check("out.e2.stall", 32'(Stall), 32'h1);
    check("out.e2.wr", 32'(notWR), 32'h0);
    tick();
    check("out.e3.stall", 32'(Stall), 32'h1);
    check("out.e3.wr", 32'(notWR), 32'h0);
    tick();
    check("out.e4.stall", 32'(Stall), 32'h1);
    check("out.e4.wr", 32'(notWR), 32'h0);
    notWAIT = 1'b1; tick();
    check("out.e5.stall", 32'(Stall), 32'h0);
    check("out.e5.wr", 32'(notWR), 32'h0);
    check("out.e5.oe", 32'(BusDataOE), 32'h1);
    pco = 4'b1000; tick();
    check_strobes("out.e6", 1'b0, 1'b1, 1'b0);
    check("out.e6.dout", 32'(BusDataOut), 32'hC3);
    check("out.e6.valid", 32'(InDataValid), 32'h0);
    check("out.e6.perr", 32'(ProtoErr), 32'h0);
    pco = 4'b0000; tick();
    check_strobes("out.e7", 1'b1, 1'b1, 1'b1);
    check("out.e7.oe", 32'(BusDataOE), 32'h0);
    check("out.e7.tmo", 32'(Timeout), 32'h0);

    // Wait timeout after the fifth stalled TW cycle
    AddrBC = 16'h0777; pci = 4'b0001; tick();
    pci = 4'b0010; tick();
    pci = 4'b0100; notWAIT = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      check("tmo.stall", 32'(Stall), 32'h1);
      check("tmo.tmo0", 32'(Timeout), 32'h0);
      tick();
    end
    check("tmo.stall4", 32'(Stall), 32'h1);
    check("tmo.iorq4", 32'(notIORQ), 32'h0);
    tick();
    check("tmo.tmo", 32'(Timeout), 32'h1);
    check_strobes("tmo.rel", 1'b1, 1'b1, 1'b1);
    check("tmo.stall5", 32'(Stall), 32'h0);
    check("tmo.perr", 32'(ProtoErr), 32'h0);
    check("tmo.valid", 32'(InDataValid), 32'h0);
    pci = 4'b0000; notWAIT = 1'b1; tick();

    // Back-to-back: OUT started in T3 of an IN
    AddrBC = 16'h0111; pci = 4'b0001; tick();
    pci = 4'b0010; tick();
    pci = 4'b0100; tick();
    pci = 4'b1000; BusDataIn = 8'h96; tick();
    check("b2b.e3.iorq", 32'(notIORQ), 32'h0);
    check("b2b.e3.indata", 32'(InData), 32'h96);
    pci = 4'b0000; pco = 4'b0001; AddrBC = 16'h4321; DataOut = 8'h7E; tick();
    check("b2b.e4.iorq", 32'(notIORQ), 32'h1);
    check("b2b.e4.addr", 32'(BusAddr), 32'h4321);
    check("b2b.e4.dout", 32'(BusDataOut), 32'h7E);
    pco = 4'b0010; tick();
    check_strobes("b2b.e5", 1'b0, 1'b1, 1'b0);
    check("b2b.e5.oe", 32'(BusDataOE), 32'h1);
    check("b2b.e5.perr", 32'(ProtoErr), 32'h0);
    pco = 4'b0100; tick();
    pco = 4'b1000; tick();
    pco = 4'b0000; tick();
    check_strobes("b2b.end", 1'b1, 1'b1, 1'b1);
    check("b2b.end.indata", 32'(InData), 32'h96);

    // Order violation, then a legal IN right behind it
    AddrBC = 16'h0ABC; pci = 4'b0001; tick();
    pci = 4'b0000; pco = 4'b0010; tick();
    check("ord.perr", 32'(ProtoErr), 32'h1);
    check_strobes("ord", 1'b1, 1'b1, 1'b1);
    check("ord.addr", 32'(BusAddr), 32'h0ABC);
    pco = 4'b0000; AddrBC = 16'h0BCD; pci = 4'b0001; tick();
    check("ord.in.addr", 32'(BusAddr), 32'h0BCD);
    pci = 4'b0010; tick();
    check_strobes("ord.in.e1", 1'b0, 1'b0, 1'b1);
    pci = 4'b0100; tick();
    pci = 4'b1000; BusDataIn = 8'h3C; tick();
    check("ord.in.indata", 32'(InData), 32'h3C);
    check("ord.in.valid", 32'(InDataValid), 32'h1);
    check("ord.in.perr", 32'(ProtoErr), 32'h1);
    pci = 4'b0000; tick();

    // Wrong-direction strobe in TW releases the bus and keeps latches
    pci = 4'b0001; tick();
    pci = 4'b0010; tick();
    pci = 4'b0100; tick();
    check("twv.iorq", 32'(notIORQ), 32'h0);
    pci = 4'b0000; pco = 4'b1000; BusDataIn = 8'hEE; tick();
    check_strobes("twv", 1'b1, 1'b1, 1'b1);
    check("twv.valid", 32'(InDataValid), 32'h0);
    check("twv.indata", 32'(InData), 32'h3C);
    pco = 4'b0000; tick();

    // Asynchronous reset while stalled in TW
    pci = 4'b0001; tick();
    pci = 4'b0010; tick();
    pci = 4'b0100; notWAIT = 1'b0; tick();
    check("ar.stall", 32'(Stall), 32'h1);
    check("ar.iorq", 32'(notIORQ), 32'h0);
    #2 notReset = 1'b0;
    #1 check_reset_vals("ar.async");
    tick();
    check_reset_vals("ar.held");
    pci = 4'b0000; notWAIT = 1'b1; notReset = 1'b1;

    // Two strobes at once in IDLE is illegal and latches nothing
    AddrBC = 16'h5555; pci = 4'b0001; pco = 4'b0001; tick();
    check("multi.perr", 32'(ProtoErr), 32'h1);
    check("multi.addr", 32'(BusAddr), 32'h0);
    check_strobes("multi", 1'b1, 1'b1, 1'b1);
    pci = 4'b0000; pco = 4'b0000; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_cycle_sequencer.md
# io_cycle_sequencer

Bus-side I/O cycle engine for the IN r,(C) / OUT (C),r execution path. It sits directly downstream of the XOTR `01xxx00` decoder and consumes its per-step strobes `PC_I0..PC_I3` and `PC_O0..PC_O3`. It drives the external `notIORQ`/`notRD`/`notWR` handshake, the port address and the write data. It samples `notWAIT` and returns a `Stall` that freezes the XPT step counter, and it latches IN data for the register-write step.

## Interface
- `ADDR_WIDTH`, 16, width of port address (BC).
- `WAIT_TIMEOUT`, 255, maximum consecutive stalled TW cycles before timeout (1..255).

- `CLK` in 1: single clock; all state updates on rising edge.
- `notReset` in 1: asynchronous, active-low reset.
- `PC_I0..PC_I3` in 1 each: IN step strobes, one per XPT step 4..7.
- `PC_O0..PC_O3` in 1 each: OUT step strobes, one per XPT step 4..7.
- `AddrBC` in ADDR_WIDTH: BC register value, valid with step-0 strobe.
- `DataOut` in 8: source register value for OUT, valid with `PC_O0`.
- `BusDataIn` in 8: external data bus input.
- `notWAIT` in 1: external wait request, active low, asynchronous to the cycle.
- `BusAddr` out ADDR_WIDTH: registered port address.
- `BusDataOut` out 8: registered write data.
- `BusDataOE` out 1: data-bus drive enable (OUT only).
- `notIORQ`, `notRD`, `notWR` out 1 each: bus strobes, active low.
- `InData` out 8: latched IN data.
- `InDataValid` out 1: one-cycle pulse when `InData` updates.
- `Stall` out 1: hold XPT; combinational from registered state.
- `ProtoErr` out 1: sticky protocol-violation flag.
- `Timeout` out 1: sticky wait-timeout flag.

## Operation
- States: IDLE, T1, T2, TW, T3. Direction bit `dir` (0=IN, 1=OUT) is latched at start.
- Strobe group: exactly one of the eight strobes high = valid strobe `x<k>`. More than one high = illegal.
- IDLE:
  - `x0` -> T1. Latch `dir`, `BusAddr<=AddrBC`. If OUT, `BusDataOut<=DataOut`.
  - Any other strobe -> `ProtoErr`, stay IDLE.
  - No strobe -> hold.
- T1: `x1` of the same `dir` -> T2. `notIORQ<=0`; `notRD<=0` (IN) or `notWR<=0` (OUT); `BusDataOE<=dir`.
- T2: `x2` -> TW.
- TW:
  - `notWAIT_q` is `notWAIT` registered once, reset value 1.
  - `Stall = (state==TW) & ~notWAIT_q`.
  - Repeated `x2` is legal and holds state.
  - `x3` with `notWAIT_q=1` -> T3. If IN, `InData<=BusDataIn` and `InDataValid<=1`.
  - `x3` with `notWAIT_q=0` is illegal.
- T3: always lasts one cycle.
  - Leaving edge sets `notIORQ`, `notRD` and `notWR` to 1 and `BusDataOE` to 0.
  - `x0` in T3 starts a new cycle (-> T1) with the same latches as IDLE.
  - No strobe -> IDLE. Any other strobe -> `ProtoErr`.
- In T1/T2/TW, no strobe holds state. A strobe of wrong index or wrong `dir` is illegal.
- Illegal event:
  - `ProtoErr<=1`, state -> IDLE.
  - Bus strobes deasserted, `BusDataOE<=0`, `Stall=0`.
  - `BusAddr`/`BusDataOut`/`InData` keep their values.
- Wait counter: 8-bit `waitcnt` clears on TW entry and increments each TW cycle with `Stall=1`. When `waitcnt==WAIT_TIMEOUT` and `Stall=1`: `Timeout<=1`, abort exactly as an illegal event, but `ProtoErr` is not set.
- `ProtoErr` and `Timeout` clear only on reset.

## Timing
- Reset values:
  - State IDLE; `notIORQ=notRD=notWR=1`.
  - `BusDataOE=0`, `BusAddr=0`, `BusDataOut=0`, `InData=0`.
  - `InDataValid=0`, `Stall=0`, `ProtoErr=0`, `Timeout=0`, `notWAIT_q=1`, `waitcnt=0`.
- `notReset` low mid-cycle deasserts the bus strobes immediately, asynchronously.
- All outputs except `Stall` are registered; each changes on the edge that samples its causing strobe.
- `notWAIT` latency: 1 cycle to `notWAIT_q`, so `Stall` reflects `notWAIT` as sampled on the previous edge.
- No-wait cycle: strobes on 4 consecutive edges E0..E3.
  - `notIORQ` low from E1 until E4 (3 cycles).
  - `InDataValid` high for E3..E4.

## Test plan
- IN, no wait:
  - Stimulus: `AddrBC=0x12FE`, `PC_I0..I3` on 4 consecutive cycles, `BusDataIn=0x5A` at E3.
  - Required: `BusAddr=0x12FE` after E0; `notIORQ`/`notRD` low for 3 cycles; `notWR` stays 1; `InData=0x5A` with `InDataValid` pulse after E3; `BusDataOE` never 1.
- OUT with waits:
  - Stimulus: `DataOut=0xC3`; `notWAIT` low for 3 cycles while in TW; `PC_O2` held until `Stall` falls.
  - Required: `Stall` high exactly 3 cycles; `notWR` low for 6 cycles; `BusDataOE=1`, `BusDataOut=0xC3` throughout; `InDataValid` stays 0.
- Order violation: `PC_I0` then `PC_O1` -> `ProtoErr=1`, state IDLE, all bus strobes 1 next cycle. A following legal IN completes normally with `ProtoErr` still 1.
- Timeout: `WAIT_TIMEOUT=4`, `notWAIT` held low -> `Timeout=1` after the 5th stalled TW cycle; strobes released; `ProtoErr=0`.
- Reset mid-cycle: `notReset` pulled low in TW with `notIORQ` low -> `notIORQ`, `notRD`, `notWR` go to 1 and `Stall` to 0 without a clock edge; all outputs hold reset values.
- Back-to-back: `PC_O0` asserted in T3 of a preceding IN -> new T1 entered with no IDLE cycle; `notIORQ` high for exactly 1 cycle between the two cycles.
